// File: rtl/mem_queue_ctrl.sv
// In-order load/store queue: captures AGU results, issues one data-cache access
// at a time in program order and broadcasts completions on the CDB.
module mem_queue_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROB_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dispatch_valid,
  input  logic [ROB_IDX_W-1:0] dispatch_rob_idx,
  input  logic                 dispatch_is_store,
  input  logic [2:0]           dispatch_funct3,
  output logic                 full,
  input  logic                 agu_valid,
  input  logic [ROB_IDX_W-1:0] agu_rob_idx,
  input  logic [31:0]          agu_addr,
  input  logic [31:0]          agu_wdata,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  input  logic                 flush,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [31:0]          cdb_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [DEPTH-1:0]     ent_valid;
  logic [DEPTH-1:0]     ent_is_store;
  logic [DEPTH-1:0]     ent_addr_valid;
  logic [ROB_IDX_W-1:0] ent_rob_idx [DEPTH];
  logic [2:0]           ent_funct3  [DEPTH];
  logic [31:0]          ent_addr    [DEPTH];
  logic [31:0]          ent_wdata   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       state;
  logic [1:0]       state_d;

  // Attributes of the access in flight, kept so the response needs no queue lookup.
  logic [ROB_IDX_W-1:0] req_rob_idx;
  logic [2:0]           req_funct3;
  logic [1:0]           req_off;
  logic                 req_is_store;

  logic        head_eligible_c;
  logic        issue_c;
  logic        pop_c;
  logic        push_c;
  logic        cdb_fire_c;
  logic        clear_req_c;
  logic [1:0]  head_off_c;
  logic [3:0]  head_mask_c;
  logic [31:0] head_wdata_c;
  logic [31:0] shifted_c;
  logic [31:0] load_data_c;

  assign push_c = dispatch_valid && !full && !flush;

  // Next-state and issue/complete decisions.
  always_comb begin
    state_d         = state;
    issue_c         = 1'b0;
    pop_c           = 1'b0;
    cdb_fire_c      = 1'b0;
    clear_req_c     = 1'b0;
    head_eligible_c = ent_valid[head] && ent_addr_valid[head] &&
                      (!ent_is_store[head] || (ent_rob_idx[head] == rob_head_idx));
    case (state)
      S_IDLE: begin
        if (head_eligible_c && !flush) begin
          issue_c = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_resp) begin
          clear_req_c = 1'b1;
          pop_c       = !flush;
          cdb_fire_c  = !flush;
          state_d     = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dmem_resp) begin
          clear_req_c = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count;
    case ({push_c, pop_c})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Byte-lane alignment of the head request.
  assign head_off_c   = ent_addr[head][1:0];
  assign head_wdata_c = ent_wdata[head] << {head_off_c, 3'b000};

  always_comb begin
    head_mask_c = 4'b1111;
    case (ent_funct3[head][1:0])
      2'b00:   head_mask_c = 4'(4'b0001 << head_off_c);
      2'b01:   head_mask_c = 4'(4'b0011 << head_off_c);
      default: head_mask_c = 4'b1111;
    endcase
  end

  // Load result extraction and extension.
  assign shifted_c = dmem_rdata >> {req_off, 3'b000};

  always_comb begin
    load_data_c = shifted_c;
    case (req_funct3)
      3'b000:  load_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  load_data_c = {24'h0, shifted_c[7:0]};
      3'b101:  load_data_c = {16'h0, shifted_c[15:0]};
      default: load_data_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid      <= '0;
      ent_is_store   <= '0;
      ent_addr_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rob_idx[i] <= '0;
        ent_funct3[i]  <= '0;
        ent_addr[i]    <= '0;
        ent_wdata[i]   <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (flush) begin
      ent_valid      <= '0;
      ent_addr_valid <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      full           <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (agu_valid && ent_valid[i] && (ent_rob_idx[i] == agu_rob_idx)) begin
          ent_addr_valid[i] <= 1'b1;
          ent_addr[i]       <= agu_addr;
          ent_wdata[i]      <= agu_wdata;
        end
      end
      if (push_c) begin
        ent_valid[tail]      <= 1'b1;
        ent_addr_valid[tail] <= 1'b0;
        ent_rob_idx[tail]    <= dispatch_rob_idx;
        ent_is_store[tail]   <= dispatch_is_store;
        ent_funct3[tail]     <= dispatch_funct3;
        tail                 <= tail + PTR_W'(1);
      end
      if (pop_c) begin
        ent_valid[head]      <= 1'b0;
        ent_addr_valid[head] <= 1'b0;
        head                 <= head + PTR_W'(1);
      end
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Cache request registers; held from issue through the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr    <= '0;
      dmem_rmask   <= '0;
      dmem_wmask   <= '0;
      dmem_wdata   <= '0;
      req_rob_idx  <= '0;
      req_funct3   <= '0;
      req_off      <= '0;
      req_is_store <= 1'b0;
    end else if (issue_c) begin
      dmem_addr    <= {ent_addr[head][31:2], 2'b00};
      dmem_rmask   <= ent_is_store[head] ? 4'b0000 : head_mask_c;
      dmem_wmask   <= ent_is_store[head] ? head_mask_c : 4'b0000;
      dmem_wdata   <= ent_is_store[head] ? head_wdata_c : 32'h0;
      req_rob_idx  <= ent_rob_idx[head];
      req_funct3   <= ent_funct3[head];
      req_off      <= head_off_c;
      req_is_store <= ent_is_store[head];
    end else if (clear_req_c) begin
      dmem_rmask <= '0;
      dmem_wmask <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_data    <= '0;
    end else begin
      cdb_valid <= cdb_fire_c;
      if (cdb_fire_c) begin
        cdb_rob_idx <= req_rob_idx;
        cdb_data    <= req_is_store ? 32'h0 : load_data_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_queue_ctrl.sv
// Directed bench for mem_queue_ctrl with hand-computed expectations.
module tb_mem_queue_ctrl;

  localparam int unsigned ROB_IDX_W = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 dispatch_valid;
  logic [ROB_IDX_W-1:0] dispatch_rob_idx;
  logic                 dispatch_is_store;
  logic [2:0]           dispatch_funct3;
  logic                 full;
  logic                 agu_valid;
  logic [ROB_IDX_W-1:0] agu_rob_idx;
  logic [31:0]          agu_addr;
  logic [31:0]          agu_wdata;
  logic [ROB_IDX_W-1:0] rob_head_idx;
  logic                 flush;
  logic [31:0]          dmem_addr;
  logic [3:0]           dmem_rmask;
  logic [3:0]           dmem_wmask;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  logic                 dmem_resp;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [31:0]          cdb_data;

  int total = 0;
  int bad   = 0;

  mem_queue_ctrl #(.DEPTH(8), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_is_store(dispatch_is_store), .dispatch_funct3(dispatch_funct3),
    .full(full),
    .agu_valid(agu_valid), .agu_rob_idx(agu_rob_idx), .agu_addr(agu_addr),
    .agu_wdata(agu_wdata), .rob_head_idx(rob_head_idx), .flush(flush),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int rob, input logic st, input logic [2:0] f3);
    dispatch_valid    = 1'b1;
    dispatch_rob_idx  = ROB_IDX_W'(rob);
    dispatch_is_store = st;
    dispatch_funct3   = f3;
    tick();
    dispatch_valid = 1'b0;
  endtask

  task automatic agu(input int rob, input logic [31:0] addr, input logic [31:0] wdata);
    agu_valid   = 1'b1;
    agu_rob_idx = ROB_IDX_W'(rob);
    agu_addr    = addr;
    agu_wdata   = wdata;
    tick();
    agu_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && (dmem_rmask == 4'b0) && (dmem_wmask == 4'b0); i++) tick();
    check(tag, 32'((dmem_rmask != 4'b0) || (dmem_wmask != 4'b0)), 32'd1);
  endtask

  // Request is visible now; respond after lat cycles total (lat >= 1).
  task automatic serve(input int lat, input logic [31:0] rdata);
    for (int i = 1; i < lat; i++) tick();
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    tick();
    dmem_resp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dispatch_valid = 1'b0; dispatch_rob_idx = '0; dispatch_is_store = 1'b0;
    dispatch_funct3 = 3'd0; agu_valid = 1'b0; agu_rob_idx = '0; agu_addr = '0;
    agu_wdata = '0; rob_head_idx = 6'd63; flush = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0;
    tick(); tick();
    check("rst_full", 32'(full), 32'd0);
    check("rst_rmask", 32'(dmem_rmask), 32'd0);
    check("rst_wmask", 32'(dmem_wmask), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_rob", 32'(cdb_rob_idx), 32'd0);
    check("rst_cdb_data", cdb_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // LW to 0x100, 2-cycle response
    dispatch(1, 1'b0, 3'b010);
    agu(1, 32'h100, 32'h0);
    check("lw_not_yet", 32'(dmem_rmask), 32'd0);
    tick();
    check("lw_rmask", 32'(dmem_rmask), 32'hF);
    check("lw_addr", dmem_addr, 32'h100);
    tick();
    check("lw_rmask_held", 32'(dmem_rmask), 32'hF);
    check("lw_cdb_quiet", 32'(cdb_valid), 32'd0);
    serve(1, 32'hDEADBEEF);
    check("lw_cdb_valid", 32'(cdb_valid), 32'd1);
    check("lw_cdb_data", cdb_data, 32'hDEADBEEF);
    check("lw_cdb_rob", 32'(cdb_rob_idx), 32'd1);
    check("lw_rmask_clr", 32'(dmem_rmask), 32'd0);
    tick();
    check("lw_cdb_pulse", 32'(cdb_valid), 32'd0);

    // LB then LBU at 0x103
    dispatch(2, 1'b0, 3'b000);
    dispatch(3, 1'b0, 3'b100);
    agu(2, 32'h103, 32'h0);
    agu(3, 32'h103, 32'h0);
    wait_req("lb_req");
    check("lb_rmask", 32'(dmem_rmask), 32'h8);
    check("lb_addr", dmem_addr, 32'h100);
    serve(1, 32'h80123456);
    check("lb_cdb_data", cdb_data, 32'hFFFFFF80);
    check("lb_cdb_rob", 32'(cdb_rob_idx), 32'd2);
    wait_req("lbu_req");
    serve(2, 32'h80123456);
    check("lbu_cdb_data", cdb_data, 32'h00000080);
    check("lbu_cdb_rob", 32'(cdb_rob_idx), 32'd3);

    // SH at 0x102 waits for ROB head
    dispatch(4, 1'b1, 3'b001);
    agu(4, 32'h102, 32'h1234);
    tick(); tick(); tick();
    check("sh_blocked", 32'(dmem_wmask), 32'd0);
    rob_head_idx = 6'd4;
    wait_req("sh_req");
    check("sh_wmask", 32'(dmem_wmask), 32'hC);
    check("sh_rmask", 32'(dmem_rmask), 32'd0);
    check("sh_wdata", dmem_wdata, 32'h12340000);
    check("sh_addr", dmem_addr, 32'h100);
    serve(2, 32'hFFFFFFFF);
    check("sh_cdb_valid", 32'(cdb_valid), 32'd1);
    check("sh_cdb_data", cdb_data, 32'd0);
    check("sh_cdb_rob", 32'(cdb_rob_idx), 32'd4);
    rob_head_idx = 6'd63;

    // Fill to full, ninth dispatch dropped
    for (int i = 0; i < 7; i++) dispatch(10 + i, 1'b0, 3'b010);
    check("full_at_7", 32'(full), 32'd0);
    dispatch(17, 1'b0, 3'b010);
    check("full_at_8", 32'(full), 32'd1);
    dispatch(18, 1'b0, 3'b010);
    check("full_ninth", 32'(full), 32'd1);
    agu(10, 32'h200, 32'h0);
    wait_req("full_pop_req");
    check("full_pop_addr", dmem_addr, 32'h200);
    serve(1, 32'h11);
    check("full_drop", 32'(full), 32'd0);
    check("full_pop_rob", 32'(cdb_rob_idx), 32'd10);
    dispatch(19, 1'b0, 3'b010);
    check("full_refill", 32'(full), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_full", 32'(full), 32'd0);

    // Out-of-order AGU results, in-order completion
    dispatch(20, 1'b0, 3'b010);
    dispatch(21, 1'b0, 3'b010);
    dispatch(22, 1'b0, 3'b010);
    agu(22, 32'h308, 32'h0);
    agu(21, 32'h304, 32'h0);
    tick(); tick();
    check("ooo_blocked", 32'(dmem_rmask), 32'd0);
    agu(20, 32'h300, 32'h0);
    wait_req("ooo_req0");
    check("ooo_addr0", dmem_addr, 32'h300);
    serve(1, 32'hA0);
    check("ooo_rob0", 32'(cdb_rob_idx), 32'd20);
    wait_req("ooo_req1");
    check("ooo_addr1", dmem_addr, 32'h304);
    serve(1, 32'hA1);
    check("ooo_rob1", 32'(cdb_rob_idx), 32'd21);
    wait_req("ooo_req2");
    check("ooo_addr2", dmem_addr, 32'h308);
    serve(1, 32'hA2);
    check("ooo_rob2", 32'(cdb_rob_idx), 32'd22);
    check("ooo_data2", cdb_data, 32'hA2);

    // Flush during WAIT on a load; same-cycle dispatch is dropped
    dispatch(30, 1'b0, 3'b010);
    agu(30, 32'h400, 32'h0);
    wait_req("fl_req");
    flush = 1'b1;
    dispatch(40, 1'b0, 3'b010);
    flush = 1'b0;
    check("fl_rmask_held", 32'(dmem_rmask), 32'hF);
    check("fl_addr_held", dmem_addr, 32'h400);
    dispatch(31, 1'b0, 3'b010);
    check("fl_rmask_drain", 32'(dmem_rmask), 32'hF);
    serve(1, 32'h55);
    check("fl_no_cdb", 32'(cdb_valid), 32'd0);
    check("fl_rmask_clr", 32'(dmem_rmask), 32'd0);
    agu(40, 32'h600, 32'h0);
    tick(); tick();
    check("fl_drop_dispatch", 32'(dmem_rmask), 32'd0);
    agu(31, 32'h500, 32'h0);
    wait_req("fl_new_req");
    check("fl_new_addr", dmem_addr, 32'h500);
    serve(1, 32'h66);
    check("fl_new_rob", 32'(cdb_rob_idx), 32'd31);

    // Flush in the response cycle suppresses the broadcast
    dispatch(50, 1'b0, 3'b010);
    agu(50, 32'h700, 32'h0);
    wait_req("flr_req");
    flush = 1'b1;
    serve(1, 32'h77);
    flush = 1'b0;
    check("flr_no_cdb", 32'(cdb_valid), 32'd0);
    check("flr_rmask_clr", 32'(dmem_rmask), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_queue_ctrl.md
# mem_queue_ctrl

In-order load/store queue controller for the out-of-order core's memory path. It holds dispatched memory ops and captures the effective address and store data from the memory address-generation unit. It issues one access at a time to the data-cache port in program order, and broadcasts completions on the CDB. Loads issue as soon as they reach the queue head with a valid address. Stores issue only when they are also the ROB head.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, ≥2.
- ROB_IDX_W, 6: ROB index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dispatch_valid  in  1  enqueue a memory op this cycle.
- dispatch_rob_idx  in  ROB_IDX_W  ROB index of the op.
- dispatch_is_store  in  1  1 = store, 0 = load.
- dispatch_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- full  out  1  queue full; dispatch is ignored while high.
- agu_valid  in  1  AGU result valid.
- agu_rob_idx  in  ROB_IDX_W  ROB index of the AGU result.
- agu_addr  in  32  effective address.
- agu_wdata  in  32  store data, unshifted.
- rob_head_idx  in  ROB_IDX_W  current ROB head index.
- flush  in  1  squash all queued ops.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_rmask  out  4  read byte mask.
- dmem_wmask  out  4  write byte mask.
- dmem_wdata  out  32  store data shifted to byte lanes.
- dmem_rdata  in  32  load data, valid with dmem_resp.
- dmem_resp  in  1  access complete, one-cycle pulse.
- cdb_valid  out  1  completion broadcast.
- cdb_rob_idx  out  ROB_IDX_W  completing ROB index.
- cdb_data  out  32  load result; 0 for stores.

## Operation
- Circular buffer with head/tail pointers and a count, giving distinct full and empty states.
- Each entry holds: valid, rob_idx, is_store, funct3, addr_valid, addr, wdata.
- Dispatch: if dispatch_valid && !full, write the entry at tail, clear addr_valid, and advance tail.
- AGU capture: a valid entry with rob_idx == agu_rob_idx latches addr/wdata and sets addr_valid. An entry dispatched in the same cycle is not a match candidate.
- FSM states:
  - IDLE: issue the head when it is valid && addr_valid && (!is_store || rob_idx == rob_head_idx), then go to WAIT.
  - WAIT: drive the request stable until dmem_resp. On dmem_resp, pop the head, register the CDB result, and go to IDLE.
  - DRAIN: entered from WAIT on flush; wait for dmem_resp, then go to IDLE with no CDB broadcast.
- Byte masks:
  - Byte access: 4'b0001 << addr[1:0].
  - Half access: 4'b0011 << addr[1:0].
  - Word access: 4'b1111.
  - Masks are truncated to 4 bits. Misaligned accesses are not generated upstream.
- Store data: wdata << (8*addr[1:0]).
- Load result: rdata >> (8*addr[1:0]), then sign- or zero-extended per funct3.
- Flush:
  - Clears all entries, head, tail and count in the same edge, and dispatch in that cycle is dropped.
  - An in-flight access is never cancelled: WAIT goes to DRAIN, and the access completes at the cache (a committed store still writes).
  - A flush arriving in the dmem_resp cycle suppresses the CDB broadcast.

## Timing
- Reset values: all entries invalid, pointers 0, state IDLE, full=0, dmem_rmask=0, dmem_wmask=0, dmem_addr=0, dmem_wdata=0, cdb_valid=0, cdb_rob_idx=0, cdb_data=0.
- Masks are registered outputs:
  - They rise the cycle after the head becomes eligible.
  - They stay high through the dmem_resp cycle.
  - They are 0 the cycle after dmem_resp.
- cdb_valid is a one-cycle pulse, the cycle after dmem_resp.
- Next issue is no earlier than the cycle after dmem_resp, so throughput is one access per (cache latency + 1) cycles.
- full is computed from the registered count. Pop and push in the same cycle while full: the push is ignored.
- AGU write and issue eligibility: an address latched at edge N allows the request to be driven after edge N+1.

## Test plan
- Load to address 0x100 with LW, dmem_rdata=0xDEADBEEF with 2-cycle resp: rmask=4'b1111 and dmem_addr=0x100 held until resp; next cycle cdb_valid=1 with cdb_data=0xDEADBEEF.
- LB at address 0x103 with rdata=0x80xxxxxx gives cdb_data=0xFFFFFF80; LBU at the same address gives 0x00000080.
- SH at address 0x102 with wdata=0x1234 while rob_head_idx≠idx: no issue. When rob_head_idx==idx: wmask=4'b1100 and dmem_wdata=0x12340000; CDB data 0.
- Dispatch 8 ops with no AGU results: full=1, and a ninth dispatch is ignored. Completing one op drops full the next cycle.
- AGU results arrive out of order (entry 2 before entry 0): no issue until entry 0 has its address; completions appear in program order.
- Flush during WAIT on a load: the queue empties immediately, the request is held until resp, and there is no CDB pulse. A new dispatch is accepted the cycle after the flush.
